// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the iterative multiply/divide unit: operation
// encodings carried on MDUOp, the control FSM state encoding and the helper
// that sizes the iteration counter for a given operand width.
// -----------------------------------------------------------------------------
package mdu_pkg;

   // Operation select as presented on MDUOp
   typedef enum logic [1:0] {
      MDU_MULT  = 2'b00,
      MDU_MULTU = 2'b01,
      MDU_DIV   = 2'b10,
      MDU_DIVU  = 2'b11
   } mdu_op_e;

   // Control FSM states
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } mdu_state_e;

   // Default operand / HI / LO width
   localparam int MDU_DATA_WIDTH = 32;

   // Iteration counter width: wide enough to hold DATA_WIDTH itself
   function automatic int mdu_cnt_width(input int data_width);
      return $clog2(data_width + 1);
   endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// -----------------------------------------------------------------------------
// mul_div_unit_if
// Request/result bundle between the core control path and the MDU.
//   Start    request a new operation (taken only while Busy = 0)
//   MDUOp    00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   SrcA     multiplicand / dividend
//   SrcB     multiplier / divisor
//   Busy     operation in progress (PC stall)
//   Done     one-cycle pulse, HI/LO valid from this cycle
//   HI, LO   product high/low word, or remainder/quotient
//   DivZero  divide with SrcB = 0, held until the next accepted Start
// Modports: master = requester (core), slave = the MDU.
// -----------------------------------------------------------------------------
interface mul_div_unit_if #(
   parameter int DATA_WIDTH = 32
) ();

   logic                  Start;
   logic [1:0]            MDUOp;
   logic [DATA_WIDTH-1:0] SrcA;
   logic [DATA_WIDTH-1:0] SrcB;
   logic                  Busy;
   logic                  Done;
   logic [DATA_WIDTH-1:0] HI;
   logic [DATA_WIDTH-1:0] LO;
   logic                  DivZero;

   modport master (
      output Start, MDUOp, SrcA, SrcB,
      input  Busy, Done, HI, LO, DivZero
   );

   modport slave (
      input  Start, MDUOp, SrcA, SrcB,
      output Busy, Done, HI, LO, DivZero
   );

endinterface

// File: rtl/mdu_shift_core.sv
// -----------------------------------------------------------------------------
// mdu_shift_core
// One-bit-per-cycle datapath shared by multiply and divide. Works purely on
// unsigned magnitudes; sign handling lives in the parent.
//   clk, rst_n  clock, asynchronous active-low reset
//   load        initialise: acc_hi = 0, acc_lo = a_mag, divisor/multiplicand = b_mag
//   step        perform one iteration
//   div_mode    0: shift-add multiply, 1: restoring divide
//   a_mag       multiplier / dividend magnitude
//   b_mag       multiplicand / divisor magnitude
//   acc_hi      product high word / partial remainder
//   acc_lo      product low word  / quotient
// After DATA_WIDTH steps {acc_hi, acc_lo} holds a*b (multiply) or
// acc_hi = a % b, acc_lo = a / b (divide).
// Build option MDU_DIV_EN: when undefined the divide step is not built and the
// core simply stays idle during divide operations.
// -----------------------------------------------------------------------------
module mdu_shift_core #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  step,
   input  logic                  div_mode,
   input  logic [DATA_WIDTH-1:0] a_mag,
   input  logic [DATA_WIDTH-1:0] b_mag,
   output logic [DATA_WIDTH-1:0] acc_hi,
   output logic [DATA_WIDTH-1:0] acc_lo
);

   logic [DATA_WIDTH-1:0] hi_r;
   logic [DATA_WIDTH-1:0] lo_r;
   logic [DATA_WIDTH-1:0] b_r;
   logic [DATA_WIDTH:0]   mul_sum_s;
   logic [DATA_WIDTH-1:0] hi_nxt_s;
   logic [DATA_WIDTH-1:0] lo_nxt_s;
`ifdef MDU_DIV_EN
   logic [DATA_WIDTH:0]   div_shift_s;
   logic [DATA_WIDTH:0]   div_diff_s;
`endif

   // Next accumulator value for one multiply or divide iteration
   always_comb begin
      // Multiply: add the multiplicand when the current multiplier bit (LSB of
      // lo) is set, then shift the whole {carry, hi, lo} right by one.
      if (lo_r[0]) begin
         mul_sum_s = {1'b0, hi_r} + {1'b0, b_r};
      end else begin
         mul_sum_s = {1'b0, hi_r};
      end
`ifdef MDU_DIV_EN
      // Divide: shift the next dividend bit into the remainder and try the
      // subtraction; a set MSB on the difference means a borrow (restore).
      div_shift_s = {hi_r, lo_r[DATA_WIDTH-1]};
      div_diff_s  = div_shift_s - {1'b0, b_r};
      if (div_mode) begin
         if (div_diff_s[DATA_WIDTH]) begin
            hi_nxt_s = div_shift_s[DATA_WIDTH-1:0];
            lo_nxt_s = {lo_r[DATA_WIDTH-2:0], 1'b0};
         end else begin
            hi_nxt_s = div_diff_s[DATA_WIDTH-1:0];
            lo_nxt_s = {lo_r[DATA_WIDTH-2:0], 1'b1};
         end
      end else begin
         hi_nxt_s = mul_sum_s[DATA_WIDTH:1];
         lo_nxt_s = {mul_sum_s[0], lo_r[DATA_WIDTH-1:1]};
      end
`else
      hi_nxt_s = mul_sum_s[DATA_WIDTH:1];
      lo_nxt_s = {mul_sum_s[0], lo_r[DATA_WIDTH-1:1]};
`endif
   end

`ifdef MDU_DIV_EN
   // Accumulator registers: load on accept, advance on every iteration
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_r <= {DATA_WIDTH{1'b0}};
         lo_r <= {DATA_WIDTH{1'b0}};
         b_r  <= {DATA_WIDTH{1'b0}};
      end else if (load) begin
         hi_r <= {DATA_WIDTH{1'b0}};
         lo_r <= a_mag;
         b_r  <= b_mag;
      end else if (step) begin
         hi_r <= hi_nxt_s;
         lo_r <= lo_nxt_s;
      end
   end
`else
   // Accumulator registers: load on accept, advance only for multiplies
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_r <= {DATA_WIDTH{1'b0}};
         lo_r <= {DATA_WIDTH{1'b0}};
         b_r  <= {DATA_WIDTH{1'b0}};
      end else if (load) begin
         hi_r <= {DATA_WIDTH{1'b0}};
         lo_r <= a_mag;
         b_r  <= b_mag;
      end else if (step && !div_mode) begin
         hi_r <= hi_nxt_s;
         lo_r <= lo_nxt_s;
      end
   end
`endif

   assign acc_hi = hi_r;
   assign acc_lo = lo_r;

endmodule

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset (aborts any operation, no Done)
//   bus     mul_div_unit_if.slave: Start, MDUOp, SrcA, SrcB in;
//           Busy, Done, HI, LO, DivZero out
// Sequence: IDLE/DONE --Start--> CALC (DATA_WIDTH iterations) -> FIX -> DONE.
// Busy covers CALC and FIX, so a Start presented in the DONE cycle is taken
// and operations can run back to back every DATA_WIDTH+2 cycles. HI/LO change
// only on the FIX->DONE edge.
// Build option MDU_DIV_EN: defined = full divider; undefined = DIV/DIVU keep
// the same timing but return HI = 0, LO = 0, DivZero = 0.
// -----------------------------------------------------------------------------
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int DATA_WIDTH = MDU_DATA_WIDTH
) (
   input  logic          clk,
   input  logic          rst_n,
   mul_div_unit_if.slave bus
);

   localparam int              CNT_W     = mdu_cnt_width(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);

   // Two's-complement negate at operand width
   function automatic logic [DATA_WIDTH-1:0] neg_w(input logic [DATA_WIDTH-1:0] x);
      return {DATA_WIDTH{1'b0}} - x;
   endfunction

   mdu_state_e            state_r;
   logic [CNT_W-1:0]      cnt_r;
   mdu_op_e               op_r;
   logic                  neg_q_r;       // product / quotient must be negated
   logic                  busy_r;
   logic                  done_r;
   logic                  div_zero_r;
   logic [DATA_WIDTH-1:0] hi_r;
   logic [DATA_WIDTH-1:0] lo_r;
`ifdef MDU_DIV_EN
   logic                  neg_r_r;       // remainder must be negated (dividend < 0)
   logic                  b_zero_r;
   logic [DATA_WIDTH-1:0] a_raw_r;       // dividend as given, returned on divide by zero
`endif

   logic                  start_acc_s;
   logic                  start_signed_s;
   logic                  a_neg_s;
   logic                  b_neg_s;
   logic [DATA_WIDTH-1:0] a_mag_s;
   logic [DATA_WIDTH-1:0] b_mag_s;
   logic                  step_s;
   logic                  core_div_s;
   logic [DATA_WIDTH-1:0] core_hi_s;
   logic [DATA_WIDTH-1:0] core_lo_s;
   logic [2*DATA_WIDTH-1:0] prod_neg_s;
   logic [DATA_WIDTH-1:0] fix_hi_s;
   logic [DATA_WIDTH-1:0] fix_lo_s;
   logic                  fix_dz_s;

   // A request is taken only when the unit is not busy (IDLE or DONE)
   assign start_acc_s = bus.Start && !busy_r && ((state_r == IDLE) || (state_r == DONE));
   assign step_s      = (state_r == CALC);
   assign core_div_s  = (op_r == MDU_DIV) || (op_r == MDU_DIVU);

   // Operand magnitudes and sign flags for the request being presented
   always_comb begin
      start_signed_s = 1'b0;
      case (mdu_op_e'(bus.MDUOp))
         MDU_MULT, MDU_DIV:   start_signed_s = 1'b1;
         MDU_MULTU, MDU_DIVU: start_signed_s = 1'b0;
         default:             start_signed_s = 1'b0;
      endcase
      a_neg_s = start_signed_s & bus.SrcA[DATA_WIDTH-1];
      b_neg_s = start_signed_s & bus.SrcB[DATA_WIDTH-1];
      // -2^(W-1) negates to itself, which is the correct unsigned magnitude
      if (a_neg_s) begin
         a_mag_s = neg_w(bus.SrcA);
      end else begin
         a_mag_s = bus.SrcA;
      end
      if (b_neg_s) begin
         b_mag_s = neg_w(bus.SrcB);
      end else begin
         b_mag_s = bus.SrcB;
      end
   end

   mdu_shift_core #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (start_acc_s),
      .step     (step_s),
      .div_mode (core_div_s),
      .a_mag    (a_mag_s),
      .b_mag    (b_mag_s),
      .acc_hi   (core_hi_s),
      .acc_lo   (core_lo_s)
   );

   // Sign correction and divide-by-zero override applied in FIX
   always_comb begin
      prod_neg_s = {(2*DATA_WIDTH){1'b0}} - {core_hi_s, core_lo_s};
      fix_hi_s   = {DATA_WIDTH{1'b0}};
      fix_lo_s   = {DATA_WIDTH{1'b0}};
      fix_dz_s   = 1'b0;
      case (op_r)
         MDU_MULT, MDU_MULTU: begin
            // Full-width product: the sign applies to the 2W-bit value
            if (neg_q_r) begin
               {fix_hi_s, fix_lo_s} = prod_neg_s;
            end else begin
               {fix_hi_s, fix_lo_s} = {core_hi_s, core_lo_s};
            end
         end
         MDU_DIV, MDU_DIVU: begin
`ifdef MDU_DIV_EN
            if (b_zero_r) begin
               fix_hi_s = a_raw_r;
               fix_lo_s = {DATA_WIDTH{1'b1}};
               fix_dz_s = 1'b1;
            end else begin
               // Truncating division: remainder follows the dividend's sign
               if (neg_q_r) begin
                  fix_lo_s = neg_w(core_lo_s);
               end else begin
                  fix_lo_s = core_lo_s;
               end
               if (neg_r_r) begin
                  fix_hi_s = neg_w(core_hi_s);
               end else begin
                  fix_hi_s = core_hi_s;
               end
            end
`else
            fix_hi_s = {DATA_WIDTH{1'b0}};
            fix_lo_s = {DATA_WIDTH{1'b0}};
            fix_dz_s = 1'b0;
`endif
         end
         default: begin
            fix_hi_s = {DATA_WIDTH{1'b0}};
            fix_lo_s = {DATA_WIDTH{1'b0}};
            fix_dz_s = 1'b0;
         end
      endcase
   end

   // Control FSM with registered Busy/Done/DivZero and HI/LO result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         cnt_r      <= {CNT_W{1'b0}};
         op_r       <= MDU_MULT;
         neg_q_r    <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         div_zero_r <= 1'b0;
         hi_r       <= {DATA_WIDTH{1'b0}};
         lo_r       <= {DATA_WIDTH{1'b0}};
`ifdef MDU_DIV_EN
         neg_r_r    <= 1'b0;
         b_zero_r   <= 1'b0;
         a_raw_r    <= {DATA_WIDTH{1'b0}};
`endif
      end else begin
         case (state_r)
            IDLE, DONE: begin
               done_r <= 1'b0;
               if (start_acc_s) begin
                  state_r    <= CALC;
                  busy_r     <= 1'b1;
                  div_zero_r <= 1'b0;
                  cnt_r      <= {CNT_W{1'b0}};
                  op_r       <= mdu_op_e'(bus.MDUOp);
                  neg_q_r    <= a_neg_s ^ b_neg_s;
`ifdef MDU_DIV_EN
                  neg_r_r    <= a_neg_s;
                  b_zero_r   <= (bus.SrcB == {DATA_WIDTH{1'b0}});
                  a_raw_r    <= bus.SrcA;
`endif
               end else begin
                  state_r <= IDLE;
               end
            end
            CALC: begin
               if (cnt_r == LAST_ITER) begin
                  cnt_r   <= {CNT_W{1'b0}};
                  state_r <= FIX;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            FIX: begin
               state_r    <= DONE;
               busy_r     <= 1'b0;
               done_r     <= 1'b1;
               hi_r       <= fix_hi_s;
               lo_r       <= fix_lo_s;
               div_zero_r <= fix_dz_s;
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               cnt_r   <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

   assign bus.Busy    = busy_r;
   assign bus.Done    = done_r;
   assign bus.HI      = hi_r;
   assign bus.LO      = lo_r;
   assign bus.DivZero = div_zero_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
// Scoreboard bench for mul_div_unit (DATA_WIDTH = 32). The driver pushes the
// reference result of every accepted request into a queue; a monitor on the
// falling edge pops and compares whenever Done is seen, and also checks that
// HI/LO/DivZero hold between results. The reference model follows the
// MDU_DIV_EN build option the same way the design does.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;

   localparam int W       = 32;
   localparam int LATENCY = W + 2;   // from driving Start to seeing Done
   localparam int BUSY_LEN = W + 1;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      logic [31:0] due;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_checks;
   int   n_pass;
   int   done_count;
   exp_t exp_q[$];

   // monitor-only state
   exp_t        mon_e;
   logic [31:0] last_hi;
   logic [31:0] last_lo;
   logic        last_dz;
   int          busy_run;
   int          last_run;

   mul_div_unit_if #(.DATA_WIDTH(W)) bif ();

   mul_div_unit #(.DATA_WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) begin
         n_pass++;
      end else begin
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference results from plain integer arithmetic
   function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input int due);
      exp_t        r;
      logic [63:0] p;
      longint      sa;
      longint      sb;
      longint      q;
      longint      m;
      sa    = longint'($signed(a));
      sb    = longint'($signed(b));
      r.hi  = 32'h0;
      r.lo  = 32'h0;
      r.dz  = 1'b0;
      r.due = due;
      case (op)
         2'b00: begin
            p    = sa * sb;
            r.hi = p[63:32];
            r.lo = p[31:0];
         end
         2'b01: begin
            p    = {32'h0, a} * {32'h0, b};
            r.hi = p[63:32];
            r.lo = p[31:0];
         end
`ifdef MDU_DIV_EN
         2'b10: begin
            if (b == 32'h0) begin
               r.hi = a; r.lo = 32'hFFFF_FFFF; r.dz = 1'b1;
            end else begin
               q    = sa / sb;
               m    = sa % sb;
               r.lo = q[31:0];
               r.hi = m[31:0];
            end
         end
         2'b11: begin
            if (b == 32'h0) begin
               r.hi = a; r.lo = 32'hFFFF_FFFF; r.dz = 1'b1;
            end else begin
               r.lo = a / b;
               r.hi = a % b;
            end
         end
`endif
         default: begin
            r.hi = 32'h0; r.lo = 32'h0; r.dz = 1'b0;
         end
      endcase
      return r;
   endfunction

   function automatic logic [31:0] pick();
      logic [31:0] corners [5];
      corners[0] = 32'h0000_0000;
      corners[1] = 32'h0000_0001;
      corners[2] = 32'hFFFF_FFFF;
      corners[3] = 32'h8000_0000;
      corners[4] = 32'h7FFF_FFFF;
      if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
      return $urandom;
   endfunction

   // Called at posedge+1: wait for Busy low, optional idle gap, present one request
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int gap);
      int guard;
      guard = 0;
      while (bif.Busy && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 200) begin
         n_checks++;
         $display("FAIL busy_timeout: Busy still high after %0d cycles, required low", guard);
      end
      repeat (gap) begin @(posedge clk); #1; end
      bif.Start = 1'b1;
      bif.MDUOp = op;
      bif.SrcA  = a;
      bif.SrcB  = b;
      exp_q.push_back(model(op, a, b, cyc + LATENCY));
      @(posedge clk); #1;
      // operands need only be valid at the accepting edge
      bif.Start = 1'b0;
      bif.MDUOp = 2'($urandom);
      bif.SrcA  = $urandom;
      bif.SrcB  = $urandom;
   endtask

   // Monitor: compare on Done, check hold behaviour elsewhere
   always @(negedge clk) begin
      if (!rst_n) begin
         last_hi  = 32'h0;
         last_lo  = 32'h0;
         last_dz  = 1'b0;
         busy_run = 0;
      end else begin
         if (bif.Busy) begin
            busy_run++;
            check("divzero_cleared_while_busy", bif.DivZero, 1'b0);
         end else begin
            if (busy_run != 0) last_run = busy_run;
            busy_run = 0;
         end
         if (bif.Done) begin
            done_count++;
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_done: Done=1 with no outstanding request (cycle %0d)", cyc);
            end else begin
               mon_e = exp_q.pop_front();
               check("hi", bif.HI, mon_e.hi);
               check("lo", bif.LO, mon_e.lo);
               check("divzero", bif.DivZero, mon_e.dz);
               check("latency_cycle", cyc, mon_e.due);
               check("busy_length", last_run, BUSY_LEN);
               check("busy_low_in_done", bif.Busy, 1'b0);
               last_hi = mon_e.hi;
               last_lo = mon_e.lo;
               last_dz = mon_e.dz;
            end
         end else begin
            check("hi_hold", bif.HI, last_hi);
            check("lo_hold", bif.LO, last_lo);
            if (!bif.Busy) check("divzero_hold", bif.DivZero, last_dz);
         end
      end
   end

   initial begin
      int dc;
      int guard;
      logic [1:0] op;
      cyc        = 0;
      n_checks   = 0;
      n_pass     = 0;
      done_count = 0;
      last_run   = 0;
      busy_run   = 0;
      last_hi    = 32'h0;
      last_lo    = 32'h0;
      last_dz    = 1'b0;
      bif.Start  = 1'b0;
      bif.MDUOp  = 2'b00;
      bif.SrcA   = 32'h0;
      bif.SrcB   = 32'h0;
      rst_n      = 1'b1;
      #2 rst_n   = 1'b0;
      #1;
      check("reset_busy", bif.Busy, 1'b0);
      check("reset_done", bif.Done, 1'b0);
      check("reset_hi", bif.HI, 32'h0);
      check("reset_lo", bif.LO, 32'h0);
      check("reset_divzero", bif.DivZero, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // directed cases
      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 0);
      issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0);
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1);
      issue(2'b11, 32'd100, 32'd0, 0);
      issue(2'b01, 32'd2, 32'd3, 0);
      issue(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 0);
      issue(2'b00, 32'h8000_0000, 32'h8000_0000, 2);

      // Start while busy must be ignored
      issue(2'b11, 32'd1000, 32'd7, 0);
      repeat (5) begin @(posedge clk); #1; end
      bif.Start = 1'b1;
      bif.MDUOp = 2'b01;
      bif.SrcA  = 32'd7;
      bif.SrcB  = 32'd7;
      @(posedge clk); #1;
      bif.Start = 1'b0;

      // randomized traffic, mostly back to back
      for (int i = 0; i < 60; i++) begin
         op = 2'($urandom_range(0, 3));
         issue(op, pick(), pick(), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      end

      // reset in the middle of a divide
      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      issue(2'b10, 32'h1234_5678, 32'h0000_0013, 0);
      repeat (9) @(posedge clk);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("abort_busy", bif.Busy, 1'b0);
      check("abort_done", bif.Done, 1'b0);
      check("abort_hi", bif.HI, 32'h0);
      check("abort_lo", bif.LO, 32'h0);
      check("abort_divzero", bif.DivZero, 1'b0);
      dc = done_count;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check("no_done_after_abort", done_count, dc);

      // recovery after reset
      issue(2'b00, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 0);
      issue(2'b11, $urandom, 32'h0000_0003, 0);

      guard = 0;
      while (exp_q.size() != 0 && guard < 200) begin
         @(posedge clk);
         guard++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit for the MIPS core, operating alongside the ALU on the same SrcA/SrcB operands. It executes MULT, MULTU, DIV and DIVU over multiple cycles and holds the 64-bit result in HI/LO registers. The HI/LO outputs feed the writeback mux next to ALUResult. The control unit stalls the PC while Busy is high.

## Interface
- DATA_WIDTH, 32: operand and HI/LO width; must be even and ≥ 4.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- Start  input  1  request a new operation; sampled only when Busy = 0.
- MDUOp  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- SrcA  input  DATA_WIDTH  multiplicand / dividend.
- SrcB  input  DATA_WIDTH  multiplier / divisor.
- Busy  output  1  high while an operation is in progress.
- Done  output  1  one-cycle pulse; HI/LO are valid from this cycle.
- HI  output  DATA_WIDTH  product high word / remainder.
- LO  output  DATA_WIDTH  product low word / quotient.
- DivZero  output  1  high with Done when a divide had SrcB = 0; held until the next accepted Start.

## Operation
- **States:**
  - IDLE → CALC on Start && !Busy. SrcA, SrcB and MDUOp are latched at this edge.
  - CALC runs DATA_WIDTH cycles, one bit per cycle, using an internal iteration counter.
  - CALC → FIX after the last iteration.
  - FIX → DONE.
  - DONE → CALC on Start; otherwise DONE → IDLE.
- **Signed ops (MULT, DIV):** operands are converted to magnitudes on latch. Sign correction is applied in FIX.
- **Multiply:** shift-add on the magnitudes. HI:LO holds the full 2·DATA_WIDTH product, so there is no overflow.
- **Divide:** restoring algorithm.
  - Quotient goes to LO, remainder to HI.
  - Quotient sign = sign(A) XOR sign(B).
  - Remainder takes the sign of the dividend (truncating division).
- **Divide by zero:**
  - LO = all ones, HI = SrcA as latched, DivZero = 1.
  - Latency is unchanged.
- **Signed overflow:** -2^(W-1) / -1 gives LO = 0x80000000, HI = 0 (for W = 32), with DivZero = 0.
- **HI/LO update:** written only on the FIX→DONE edge. They hold their values through IDLE and through any later CALC, until the next FIX.
- **Start while Busy:** ignored entirely; the in-flight operation completes unchanged.

## Timing
- **Reset values:** state = IDLE, HI = 0, LO = 0, Busy = 0, Done = 0, DivZero = 0, iteration counter = 0.
- **Latency:** Start is sampled at edge 0. Busy is high from edge 1 to edge DATA_WIDTH+1. Done and the new HI/LO appear after edge DATA_WIDTH+2, which is 34 cycles for W = 32.
- **Handshake:** Busy = 0 in the DONE cycle, so a Start in that cycle is accepted and Busy rises at the next edge. This gives back-to-back throughput of one operation per DATA_WIDTH+2 cycles.
- **Reset mid-operation:** the operation aborts immediately. All outputs take their reset values; no Done is issued.
- **Operand stability:** SrcA, SrcB and MDUOp need only be stable at the Start edge.

## Configuration
- **MDU_DIV_EN defined:** full behaviour as above.
- **MDU_DIV_EN undefined:**
  - The divider datapath is removed.
  - DIV/DIVU still follow the full CALC/FIX/DONE sequence, so timing is identical.
  - They produce HI = 0, LO = 0 and DivZero = 0.
  - Multiply is unaffected.

## Structure
- **Package mdu_pkg:** MDUOp encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU), the state enum (IDLE, CALC, FIX, DONE), and the counter width $clog2(DATA_WIDTH+1).
- **Sub-module mdu_shift_core:** the per-cycle iteration datapath (accumulator/remainder register plus add/subtract-shift step), selected by a mul/div mode bit.
- **Top level:** FSM, operand sign handling, FIX correction and the HI/LO registers.

## Test plan
- **Unsigned multiply:** MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001. Done exactly 34 cycles after Start; Busy high for 33 cycles.
- **Signed multiply:** MULT 0xFFFFFFFD (-3) × 5 → HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
- **Signed divide:** DIV -7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- **Divide by zero:** DIVU 100 / 0 → LO = 0xFFFFFFFF, HI = 0x00000064, DivZero = 1. A following MULTU 2 × 3 clears DivZero, giving LO = 6.
- **Handshake:**
  - Start with MULTU 7 × 7 pulsed mid-operation is ignored; the original result is returned.
  - Start in the DONE cycle is accepted; Done follows 34 cycles later.
- **Reset mid-operation:** assert rst_n = 0 at cycle 10 of a DIV. Busy, Done, HI and LO go to 0 asynchronously, and no Done is issued after release.
